// File: rtl/arm_pkg.sv
// arm_pkg: shared defaults and helpers for the ARM register file slice.
//   DATA_W_DEF / NUM_REGS_DEF / ADDR_W_DEF / NUM_RD_DEF : default geometry
//   NUM_WR, WB_WR_PORT, BASE_WR_PORT : write-port count and port indices
//   reg_reset_val()                  : reset value of register i (i -> i)
package arm_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 15;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned NUM_RD_DEF   = 2;

  // Write ports: lower index has higher priority on an address collision.
  localparam int unsigned NUM_WR       = 2;
  localparam int unsigned WB_WR_PORT   = 0;
  localparam int unsigned BASE_WR_PORT = 1;

  // Register i resets to i so bring-up code can identify registers.
  function automatic logic [31:0] reg_reset_val(input int unsigned idx);
    return 32'(idx);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bundles the read, write, issue and scoreboard signals of
// the register file.
//   rd_addr/rd_data/rd_busy       : NUM_RD packed read ports
//   wr0_* / wr1_*                 : WB result port / base-register port
//   issue_en/issue_addr           : destination marked busy on issue
//   busy_vec                      : registered per-register busy bits
// Modports: master (ID/WB side), slave (register file).
interface reg_file_sb_if
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;

  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;

  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register busy bits for ID hazard detection.
//   clk, rst             : clock, synchronous active-high reset
//   issue_en_i/addr_i    : sets the busy bit of the issued destination
//   clr0_en_i/addr_i     : write port 0 clears the busy bit
//   clr1_en_i/addr_i     : write port 1 clears the busy bit
//   busy_vec_o           : registered busy bits, bit i for register i
// A same-cycle set and clear resolves to set (the issuing producer is younger).
module reg_scoreboard
  import arm_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  input  logic                clr0_en_i,
  input  logic [ADDR_W-1:0]   clr0_addr_i,
  input  logic                clr1_en_i,
  input  logic [ADDR_W-1:0]   clr1_addr_i,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Out-of-range addresses never match any index, so they are ignored.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((clr0_en_i && clr0_addr_i == ADDR_W'(i)) ||
          (clr1_en_i && clr1_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (issue_en_i && issue_addr_i == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised multi-port register file with scoreboard.
//   clk, rst : clock, synchronous active-high reset (reg[i] <= i, busy <= 0)
//   bus      : reg_file_sb_if.slave
//              - NUM_RD combinational read ports (data + busy flag)
//              - two posedge write ports, port 0 wins on same address
//              - issue port setting busy bits, busy_vec output
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write-to-read
// bypass of data, with the busy flag of a bypassed address cleared unless
// that address is also being issued this cycle.
module reg_file_sb
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;

  logic                wr_en   [NUM_WR];
  logic [ADDR_W-1:0]   wr_addr [NUM_WR];
  logic [DATA_W-1:0]   wr_data [NUM_WR];
  logic                wr_vld  [NUM_WR];

  always_comb begin
    wr_en[WB_WR_PORT]     = bus.wr0_en;
    wr_addr[WB_WR_PORT]   = bus.wr0_addr;
    wr_data[WB_WR_PORT]   = bus.wr0_data;
    wr_en[BASE_WR_PORT]   = bus.wr1_en;
    wr_addr[BASE_WR_PORT] = bus.wr1_addr;
    wr_data[BASE_WR_PORT] = bus.wr1_data;
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_vld[p] = wr_en[p] && (32'(wr_addr[p]) < NUM_REGS);
    end
  end

  // Ports are applied from highest index down so port 0 lands last and wins.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      for (int unsigned n = 0; n < NUM_WR; n++) begin
        if (wr_vld[NUM_WR-1-n] && wr_addr[NUM_WR-1-n] == ADDR_W'(i)) begin
          regs_d[i] = wr_data[NUM_WR-1-n];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(reg_reset_val(i));
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue_en_i   (bus.issue_en),
    .issue_addr_i (bus.issue_addr),
    .clr0_en_i    (wr_en[WB_WR_PORT]),
    .clr0_addr_i  (wr_addr[WB_WR_PORT]),
    .clr1_en_i    (wr_en[BASE_WR_PORT]),
    .clr1_addr_i  (wr_addr[BASE_WR_PORT]),
    .busy_vec_o   (busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    // Out-of-range addresses match nothing and read as 0 / not busy.
    always_comb begin
      data = '0;
      busy = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (addr == ADDR_W'(i)) begin
          data = regs_q[i];
          busy = busy_vec[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      for (int unsigned n = 0; n < NUM_WR; n++) begin
        if (wr_vld[NUM_WR-1-n] && wr_addr[NUM_WR-1-n] == addr) begin
          data = wr_data[NUM_WR-1-n];
          busy = bus.issue_en && (bus.issue_addr == addr);
        end
      end
`endif
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[k]                  = busy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int NR = 15;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .NUM_REGS(15), .ADDR_W(4), .NUM_RD(2)) bus ();
  reg_file_sb #(.DATA_W(32), .NUM_REGS(15), .ADDR_W(4), .NUM_RD(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  reg_file_sb_if #(.DATA_W(64), .NUM_REGS(15), .ADDR_W(4), .NUM_RD(3)) wbus ();
  reg_file_sb #(.DATA_W(64), .NUM_REGS(15), .ADDR_W(4), .NUM_RD(3)) u_wide (
    .clk (clk),
    .rst (rst),
    .bus (wbus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [NR];
  bit          m_busy[NR];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i]  = 32'(i);
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.wr1_en && int'(bus.wr1_addr) < NR) m_reg[bus.wr1_addr] = bus.wr1_data;
      if (bus.wr0_en && int'(bus.wr0_addr) < NR) m_reg[bus.wr0_addr] = bus.wr0_data;
      if (bus.wr0_en && int'(bus.wr0_addr) < NR) m_busy[bus.wr0_addr] = 1'b0;
      if (bus.wr1_en && int'(bus.wr1_addr) < NR) m_busy[bus.wr1_addr] = 1'b0;
      if (bus.issue_en && int'(bus.issue_addr) < NR) m_busy[bus.issue_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input int a);
    if (a >= NR) return 32'h0;
    if (BYP) begin
      if (bus.wr0_en && int'(bus.wr0_addr) == a) return bus.wr0_data;
      if (bus.wr1_en && int'(bus.wr1_addr) == a) return bus.wr1_data;
    end
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a >= NR) return 1'b0;
    if (BYP && ((bus.wr0_en && int'(bus.wr0_addr) == a) ||
                (bus.wr1_en && int'(bus.wr1_addr) == a)))
      return bus.issue_en && int'(bus.issue_addr) == a;
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [14:0] ev;
      for (int k = 0; k < 2; k++) begin
        int a;
        a = int'(bus.rd_addr[k*4 +: 4]);
        check($sformatf("model rd_data[%0d] addr %0d", k, a),
              64'(bus.rd_data[k*32 +: 32]), 64'(exp_data(a)));
        check($sformatf("model rd_busy[%0d] addr %0d", k, a),
              64'(bus.rd_busy[k]), 64'(exp_busy(a)));
      end
      for (int i = 0; i < NR; i++) ev[i] = m_busy[i];
      check("model busy_vec", 64'(bus.busy_vec), 64'(ev));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
  endtask

  logic [31:0] vec_d0 [3] = '{32'h1111_1111, 32'hCAFE_0001, 32'h0000_0042};
  logic [31:0] vec_d1 [3] = '{32'h0000_EEEE, 32'h5555_AAAA, 32'h8000_0000};
  logic [3:0]  vec_a0 [3] = '{4'd1, 4'd13, 4'd0};
  logic [3:0]  vec_a1 [3] = '{4'd14, 4'd6, 4'd12};

  initial begin
    idle();
    bus.rd_addr = '0;
    wbus.rd_addr = '0;
    wbus.wr0_en = 1'b0; wbus.wr0_addr = '0; wbus.wr0_data = '0;
    wbus.wr1_en = 1'b0; wbus.wr1_addr = '0; wbus.wr1_data = '0;
    wbus.issue_en = 1'b0; wbus.issue_addr = '0;

    // Reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset busy_vec", 64'(bus.busy_vec), 64'h0);

    // Read all addresses on both ports
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = {4'(15 - a), 4'(a)};
      #1;
      check($sformatf("reset read p0 R%0d", a), 64'(bus.rd_data[31:0]), (a < 15) ? 64'(a) : 64'h0);
      check($sformatf("reset read p1 R%0d", 15 - a), 64'(bus.rd_data[63:32]), (a > 0) ? 64'(15 - a) : 64'h0);
      step();
    end

    // Dual write same address: port 0 wins
    bus.rd_addr = {4'd3, 4'd3};
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd3; bus.wr0_data = 32'hDEADBEEF;
    bus.wr1_en = 1'b1; bus.wr1_addr = 4'd3; bus.wr1_data = 32'h0000_1234;
    #1;
    check("dual wr same-cycle R3", 64'(bus.rd_data[31:0]), BYP ? 64'hDEADBEEF : 64'h3);
    step();
    idle();
    #1;
    check("dual wr port0 wins R3", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);

    // Issue R5, busy for three cycles, then wr0 clears it
    bus.rd_addr = {4'd5, 4'd5};
    bus.issue_en = 1'b1; bus.issue_addr = 4'd5;
    #1;
    check("R5 not busy in issue cycle", 64'(bus.rd_busy[0]), 64'h0);
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("R5 busy cycle %0d", c + 1), 64'(bus.rd_busy[0]), 64'h1);
      step();
    end
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd5; bus.wr0_data = 32'h0000_00A5;
    #1;
    check("R5 busy in write cycle", 64'(bus.rd_busy[0]), BYP ? 64'h0 : 64'h1);
    check("R5 data in write cycle", 64'(bus.rd_data[31:0]), BYP ? 64'hA5 : 64'h5);
    step();
    idle();
    #1;
    check("R5 busy after write", 64'(bus.rd_busy[0]), 64'h0);
    check("R5 data after write", 64'(bus.rd_data[31:0]), 64'hA5);

    // Issue and wr1 to R7 in the same cycle: set wins
    bus.rd_addr = {4'd0, 4'd7};
    bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
    bus.wr1_en = 1'b1; bus.wr1_addr = 4'd7; bus.wr1_data = 32'h0000_0077;
    step();
    idle();
    #1;
    check("R7 data after issue+wr1", 64'(bus.rd_data[31:0]), 64'h77);
    check("R7 busy_vec set wins", 64'(bus.busy_vec[7]), 64'h1);
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd7; bus.wr0_data = 32'h0000_0700;
    step();
    idle();

    // Bypassed write with issue to the same address keeps busy
    bus.rd_addr = {4'd9, 4'd9};
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd9; bus.wr0_data = 32'h0000_0099;
    bus.issue_en = 1'b1; bus.issue_addr = 4'd9;
    #1;
    check("R9 busy wr+issue cycle", 64'(bus.rd_busy[0]), BYP ? 64'h1 : 64'h0);
    step();
    idle();
    #1;
    check("R9 busy after wr+issue", 64'(bus.rd_busy[0]), 64'h1);
    bus.wr1_en = 1'b1; bus.wr1_addr = 4'd9; bus.wr1_data = 32'h0000_0999;
    step();
    idle();
    #1;
    check("R9 wr1 clears busy", 64'(bus.rd_busy[0]), 64'h0);
    check("R9 wr1 data", 64'(bus.rd_data[31:0]), 64'h999);

    // Out-of-range write/issue/read
    bus.rd_addr = {4'd15, 4'd0};
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd15; bus.wr0_data = 32'h0000_0BAD;
    bus.wr1_en = 1'b1; bus.wr1_addr = 4'd15; bus.wr1_data = 32'h0000_0BAD;
    bus.issue_en = 1'b1; bus.issue_addr = 4'd15;
    #1;
    check("addr15 read data", 64'(bus.rd_data[63:32]), 64'h0);
    check("addr15 read busy", 64'(bus.rd_busy[1]), 64'h0);
    step();
    idle();
    #1;
    check("addr15 ignored busy_vec", 64'(bus.busy_vec), 64'h0);
    check("addr15 ignored R0", 64'(bus.rd_data[31:0]), 64'h0);

    // Directed dual-port writes to distinct addresses
    for (int v = 0; v < 3; v++) begin
      bus.rd_addr = {vec_a1[v], vec_a0[v]};
      bus.wr0_en = 1'b1; bus.wr0_addr = vec_a0[v]; bus.wr0_data = vec_d0[v];
      bus.wr1_en = 1'b1; bus.wr1_addr = vec_a1[v]; bus.wr1_data = vec_d1[v];
      bus.issue_en = 1'b1; bus.issue_addr = vec_a1[v];
      step();
      idle();
      #1;
      check($sformatf("vec%0d p0", v), 64'(bus.rd_data[31:0]), 64'(vec_d0[v]));
      check($sformatf("vec%0d p1", v), 64'(bus.rd_data[63:32]), 64'(vec_d1[v]));
      check($sformatf("vec%0d p1 busy", v), 64'(bus.rd_busy[1]), 64'h1);
    end

    // Reset overrides write and issue
    bus.rd_addr = {4'd0, 4'd2};
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd2; bus.wr0_data = 32'h0000_00FF;
    step();
    idle();
    rst = 1'b1;
    bus.wr0_en = 1'b1; bus.wr0_addr = 4'd2; bus.wr0_data = 32'h0000_0011;
    bus.issue_en = 1'b1; bus.issue_addr = 4'd2;
    #1;
    check("R2 before reset edge", 64'(bus.rd_data[31:0]), BYP ? 64'h11 : 64'hFF);
    step();
    rst = 1'b0;
    idle();
    #1;
    check("R2 after reset", 64'(bus.rd_data[31:0]), 64'h2);
    check("busy_vec after reset", 64'(bus.busy_vec), 64'h0);

    // Wide build: 3 read ports, 64-bit data
    wbus.rd_addr = {4'd1, 4'd14, 4'd0};
    #1;
    check("wide R14 reset", wbus.rd_data[127:64], 64'd14);
    wbus.wr0_en = 1'b1; wbus.wr0_addr = 4'd14; wbus.wr0_data = 64'h0123_4567_89AB_CDEF;
    step();
    wbus.wr0_en = 1'b0;
    #1;
    check("wide p0 R0", wbus.rd_data[63:0], 64'h0);
    check("wide p1 R14", wbus.rd_data[127:64], 64'h0123_4567_89AB_CDEF);
    check("wide p2 R1", wbus.rd_data[191:128], 64'h1);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port ARM register file with an integrated register scoreboard. It sits between ID (reads, issue) and WB (writes) of the pipeline and replaces the fixed 15×32, 2-read/1-write register file. It adds the following over that block:
- configurable width, depth and read-port count;
- a second write port for base-register writeback;
- posedge writes with optional write-to-read bypass;
- per-register busy bits that ID uses for hazard detection.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 15, number of architectural registers (R0..R14; PC is held outside)
- ADDR_W, 4, register address width; must satisfy 2**ADDR_W >= NUM_REGS
- NUM_RD, 2, number of read ports

- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  combinational read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  combinational busy flag of each read address
- wr0_en, wr0_addr, wr0_data  in  1, ADDR_W, DATA_W  write port 0 (WB result)
- wr1_en, wr1_addr, wr1_data  in  1, ADDR_W, DATA_W  write port 1 (base-register update)
- issue_en, issue_addr  in  1, ADDR_W  marks the destination of an issued instruction as busy
- busy_vec  out  NUM_REGS  registered busy bits, bit i for register i

## Operation
- Reset (rst=1 at posedge):
  - reg[i] <= i, zero-extended to DATA_W (preserves existing bring-up tests);
  - busy_vec <= 0.
  - Reset overrides every write and issue in the same cycle.
- Write:
  - at posedge, if wrN_en and wrN_addr < NUM_REGS, then reg[wrN_addr] <= wrN_data.
  - Both ports writing the same address: port 0 wins; port 1 is dropped.
  - Address >= NUM_REGS: the write is silently ignored.
- Read:
  - rd_data[k] = reg[rd_addr[k]].
  - Address >= NUM_REGS: rd_data is 0 and rd_busy is 0.
- Scoreboard, next-state per register i:
  - set when issue_en and issue_addr == i;
  - clear when an enabled write (either port) targets i;
  - set and clear in the same cycle: set wins, because the new producer is younger.
  - Issue to an already-busy register keeps it busy. There is no counting; the pipeline guarantees in-order writeback.
- rd_busy[k] = busy_vec[rd_addr[k]], subject to the bypass rules under Configuration.

## Timing
- Write-to-storage latency is 1 cycle: data written at edge t is visible on rd_data after edge t.
- Read latency is 0 cycles (combinational).
- busy_vec changes only on posedge and is 0 from the first cycle after reset.
- Reset asserted mid-operation discards any in-flight writes and pending busy bits at that edge.
- No handshakes. Stalls are the ID stage's responsibility, based on rd_busy.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read whose address matches an enabled same-cycle write returns that write's data, with port-0 priority;
  - rd_busy for that address reads 0, unless issue_en targets the same address in that cycle.
- REGFILE_BYPASS_EN undefined:
  - reads return stored values only, and rd_busy reflects busy_vec only;
  - hazards therefore resolve one cycle later.
- Port widths and reset behaviour are identical in both builds.

## Structure
- arm_pkg holds:
  - DATA_W, NUM_REGS and ADDR_W defaults;
  - the base-register port index constant;
  - the reset-value function (i -> i).
- One sub-module, reg_scoreboard, holds busy_vec and the set/clear priority logic. It takes issue and the two write-clear inputs and outputs busy_vec.
- Storage, write priority and the read/bypass muxes stay in reg_file_sb.

## Test plan
- Reset then read all addresses: rd_data = 0..14 on each port; busy_vec = 0; address 15 reads 0.
- wr0 R3=0xDEADBEEF and wr1 R3=0x1234 in the same cycle: R3 = 0xDEADBEEF next cycle. Bypass build shows 0xDEADBEEF in the write cycle; non-bypass build shows 3.
- issue R5, then after 3 cycles wr0 R5=0xA5: rd_busy is 1 for 3 cycles, then 0. In the write cycle it is 0 in the bypass build and 1 in the non-bypass build.
- issue R7 and wr1 R7=0x77 in the same cycle: R7 = 0x77 and busy_vec[7] = 1.
- Write R2=0xFF, then assert rst together with wr0 R2=0x11 and issue R2: R2 = 2 and busy_vec = 0 after the edge.
- NUM_RD=3, DATA_W=64 build: three simultaneous reads of R0, R14 and R1 after wr0 R14=64'h0123_4567_89AB_CDEF return 0, that value and 1.
